spi_master_param: RTL and testbench
===================================

# spi_master_param

Parametrised SPI master supporting all four SPI modes, MSB- or LSB-first framing, a runtime clock divider and multiple one-hot slave selects. It sits between a register/controller front end (start/busy/done handshake) and the off-chip SPI pins. It is the generalised successor of the fixed 16-bit, mode-0, single-slave master already in the SPI directory.

## Interface
- DATA_W, 16: bits per transfer (≥2)
- DIV_W, 8: width of `div` port
- NUM_SS, 4: number of slave-select lines (≥1); SS_W = max(1, $clog2(NUM_SS))
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request transfer; accepted only in IDLE
- mode  in  2  {CPOL, CPHA}; latched on accept
- lsb_first  in  1  1 = LSB shifted first; latched on accept
- div  in  DIV_W  SCLK half period H = div+1 clk cycles; latched on accept
- ss_sel  in  SS_W  slave index; latched on accept
- data_in  in  DATA_W  transmit word; latched on accept
- miso  in  1  serial data from slave
- sclk  out  1  SPI clock
- mosi  out  1  serial data to slave
- ss_n  out  NUM_SS  active-low slave selects
- data_out  out  DATA_W  last received word, held until next done
- busy  out  1  high from accept until done edge
- done  out  1  one-cycle pulse at transfer end

## Operation
- Reset values: sclk=0, mosi=0, ss_n=all ones, data_out=0, busy=0, done=0, state IDLE.
- States: IDLE -> LEAD -> XFER -> TRAIL -> IDLE. Each phase counted in units of H clk cycles by a half-period counter.
- IDLE: sclk=CPOL (from current `mode`). On start=1: latch config and data_in, busy=1, ss_n[ss_sel]=0, go LEAD. ss_sel ≥ NUM_SS: transfer runs, no ss_n asserted.
- LEAD: H cycles, sclk at CPOL. For CPHA=0 mosi drives first bit from the accept edge.
- XFER: 2*DATA_W half periods; sclk toggles at the end of each. Edges numbered 1..2*DATA_W; odd = leading, even = trailing.
- CPHA=0: sample miso on leading edges, shift next mosi bit on trailing edges except edge 2*DATA_W.
- CPHA=1: shift mosi on leading edges (first bit on edge 1), sample on trailing edges.
- Sampling: rx shift register captures miso on the clk edge that produces the sampling sclk transition. Receive bit order follows lsb_first.
- TRAIL: H cycles, sclk back at CPOL, ss_n still asserted. At end: ss_n all ones, busy=0, done=1, data_out=received word, go IDLE. mosi returns to 0.
- start while busy: ignored, no queueing. start held high through done: new transfer accepted the cycle after done.
- Mid-transfer rst: all outputs to reset values immediately; no done pulse; data_out cleared.

## Timing
- Accept at edge k -> done high after edge k + H·(2·DATA_W+2); busy falls same edge.
- DATA_W=16, div=0: done 34 cycles after accept. div=255: H=256.
- sclk duty exactly 50 %; period 2H clk cycles.
- Earliest back-to-back accept: edge after done; ss_n high for ≥1 cycle between transfers.

## Configuration
- SPI_MASTER_LOOPBACK_EN defined: adds input `loopback` (1 bit); when 1, receiver samples the internal mosi instead of miso, pins unchanged. Not defined: port absent, receiver always samples miso.

## Test plan
- Mode 0, DATA_W=16, div=0, data_in=0xA5C3, miso echoes slave 0x3C5A -> mosi MSB-first 0xA5C3, data_out=0x3C5A, done at accept+34.
- Modes 1/2/3 with div=3, data 0x8001 -> correct idle sclk level, sample/shift edges per CPHA, data_out matches slave word, done at accept+136.
- lsb_first=1, data_in=0x0001 -> first mosi bit 1, received 0x8000 from MSB-first-shifting slave model yields data_out=0x0001.
- ss_sel=2, NUM_SS=4 -> only ss_n[2] low during busy; start pulses mid-transfer ignored; ss_sel=5 (SS_W=2 wrap not possible, use NUM_SS=3, ss_sel=3) -> no ss_n asserted, done still pulses.
- rst asserted at XFER edge 7 -> ss_n all ones, sclk=0, busy=0, no done; next transfer completes normally.
- With SPI_MASTER_LOOPBACK_EN, loopback=1, data_in=0x1234 -> data_out=0x1234 regardless of miso.

Source files
------------

// File: rtl/spi_master_param.sv
// spi_master_param: four-mode SPI master with MSB/LSB framing, runtime divider and one-hot selects.
// Optional SPI_MASTER_LOOPBACK_EN adds a `loopback` input that feeds mosi back into the receiver.
`default_nettype none

module spi_master_param #(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 8,
  parameter int NUM_SS = 4,
  parameter int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  div,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [DATA_W-1:0] data_in,
  input  logic              miso,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_SS-1:0] ss_n,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done
);

  localparam int                EDGE_W    = $clog2(2 * DATA_W + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_XFER  = 2'd2,
    S_TRAIL = 2'd3
  } state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    cnt_q;
  logic [DIV_W-1:0]    div_q;
  logic [EDGE_W-1:0]   edge_q;
  logic                cpol_q;
  logic                cpha_q;
  logic                lsb_q;
  logic [DATA_W-1:0]   tx_q;
  logic [DATA_W-1:0]   rx_q;
  logic                sclk_q;
  logic                mosi_q;
  logic                busy_q;
  logic                done_q;
  logic [NUM_SS-1:0]   ss_n_q;
  logic [DATA_W-1:0]   data_out_q;

  logic                half_end;
  logic [DIV_W-1:0]    cnt_d;
  logic [EDGE_W-1:0]   edge_d;
  logic                lead_edge;
  logic                shift_ev;
  logic                sample_ev;
  logic                rx_bit;
  logic [DATA_W-1:0]   tx_d;
  logic [DATA_W-1:0]   rx_d;
  logic [DATA_W-1:0]   tx_accept_d;
  logic                tx_first_bit;
  logic [NUM_SS-1:0]   ss_dec;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = loopback ? mosi_q : miso;
`else
  assign rx_bit = miso;
`endif

  assign half_end  = (cnt_q == div_q);
  assign cnt_d     = half_end ? '0 : cnt_q + DIV_W'(1);
  assign edge_d    = edge_q + EDGE_W'(1);
  assign lead_edge = edge_d[0];

  // CPHA=0 skips the final trailing edge so the last bit stays on mosi until TRAIL.
  assign shift_ev  = half_end && (cpha_q ? lead_edge : (!lead_edge && (edge_d != LAST_EDGE)));
  assign sample_ev = half_end && (cpha_q ? !lead_edge : lead_edge);

  assign tx_d         = lsb_q ? (tx_q >> 1) : (tx_q << 1);
  assign tx_first_bit = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
  assign rx_d         = lsb_q ? {rx_bit, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], rx_bit};
  assign tx_accept_d  = lsb_first ? (data_in >> 1) : (data_in << 1);

  always_comb begin
    ss_dec = '0;
    for (int i = 0; i < NUM_SS; i++) begin
      ss_dec[i] = (ss_sel == SS_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      edge_q     <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ss_n_q     <= '1;
      data_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          sclk_q <= mode[1];
          if (start) begin
            state_q <= S_LEAD;
            cnt_q   <= '0;
            div_q   <= div;
            edge_q  <= '0;
            cpol_q  <= mode[1];
            cpha_q  <= mode[0];
            lsb_q   <= lsb_first;
            rx_q    <= '0;
            busy_q  <= 1'b1;
            ss_n_q  <= ~ss_dec;
            // CPHA=0 presents the first bit immediately; CPHA=1 waits for edge 1.
            if (mode[0]) begin
              tx_q   <= data_in;
              mosi_q <= 1'b0;
            end else begin
              tx_q   <= tx_accept_d;
              mosi_q <= lsb_first ? data_in[0] : data_in[DATA_W-1];
            end
          end
        end
        S_LEAD: begin
          cnt_q <= cnt_d;
          if (half_end) begin
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          cnt_q <= cnt_d;
          if (half_end) begin
            sclk_q <= ~sclk_q;
            edge_q <= edge_d;
            if (edge_d == LAST_EDGE) begin
              state_q <= S_TRAIL;
            end
          end
          if (shift_ev) begin
            mosi_q <= tx_first_bit;
            tx_q   <= tx_d;
          end
          if (sample_ev) begin
            rx_q <= rx_d;
          end
        end
        S_TRAIL: begin
          cnt_q  <= cnt_d;
          sclk_q <= cpol_q;
          if (half_end) begin
            state_q    <= S_IDLE;
            ss_n_q     <= '1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            data_out_q <= rx_q;
            mosi_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign ss_n     = ss_n_q;
  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: slave model on the pins, hand-computed expectations.
`default_nettype none

module tb_spi_master_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start3 = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        lsb_first = 1'b0;
  logic [7:0]  div = 8'd0;
  logic [1:0]  ss_sel = 2'd0;
  logic [1:0]  ss_sel3 = 2'd0;
  logic [15:0] data_in = 16'h0000;
  logic        miso = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic        loopback = 1'b0;
`endif

  logic        sclk, mosi, busy, done;
  logic [3:0]  ss_n;
  logic [15:0] data_out;
  logic        sclk3, mosi3, busy3, done3;
  logic [2:0]  ss_n3;
  logic [15:0] data_out3;

  int n_chk = 0;
  int n_err = 0;

  spi_master_param #(.DATA_W(16), .DIV_W(8), .NUM_SS(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .lsb_first(lsb_first),
    .div(div), .ss_sel(ss_sel), .data_in(data_in), .miso(miso),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(loopback),
`endif
    .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .data_out(data_out), .busy(busy), .done(done)
  );

  spi_master_param #(.DATA_W(16), .DIV_W(8), .NUM_SS(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .mode(mode), .lsb_first(lsb_first),
    .div(div), .ss_sel(ss_sel3), .data_in(data_in), .miso(1'b0),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .sclk(sclk3), .mosi(mosi3), .ss_n(ss_n3), .data_out(data_out3), .busy(busy3), .done(done3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // MSB-first slave: shifts miso on its shift edge, captures mosi on the other.
  logic [15:0] slv_tx = 16'h0000;
  logic [15:0] slv_sh = 16'h0000;
  logic [15:0] slv_rx = 16'h0000;
  logic        slv_act = 1'b0;
  logic        slv_sclk = 1'b0;
  always @(negedge clk) begin
    if (ss_n != 4'hF && !slv_act) begin
      slv_sh = slv_tx;
      slv_rx = 16'h0000;
      if (!mode[0]) begin
        miso   = slv_sh[15];
        slv_sh = slv_sh << 1;
      end
    end else if (ss_n != 4'hF && sclk != slv_sclk) begin
      if ((sclk != mode[1]) == mode[0]) begin
        miso   = slv_sh[15];
        slv_sh = slv_sh << 1;
      end else begin
        slv_rx = {slv_rx[14:0], mosi};
      end
    end
    slv_act  = (ss_n != 4'hF);
    slv_sclk = sclk;
  end

  task automatic run_xfer(input string tag, input logic [1:0] m, input logic lsb, input logic [7:0] d,
                          input logic [1:0] sel, input logic [15:0] din, input logic [15:0] sword,
                          input logic [15:0] exp_dout, input logic [15:0] exp_slv, input int exp_cyc,
                          input logic [3:0] exp_ss, input bit glitch);
    int n;
    int bad;
    @(negedge clk);
    mode = m; lsb_first = lsb; div = d; ss_sel = sel; data_in = din; slv_tx = sword;
    repeat (2) @(negedge clk);
    chk({tag, "_idle_sclk"}, sclk, m[1]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_ss_n"}, ss_n, exp_ss);
    chk({tag, "_lead_sclk"}, sclk, m[1]);
    if (!m[0]) chk({tag, "_mosi0"}, mosi, lsb ? din[0] : din[15]);
    data_in = ~din;
    n = 0;
    bad = 0;
    while (!done && n < 5000) begin
      if (glitch && n == 10) start = 1'b1;
      if (n == 11) start = 1'b0;
      @(posedge clk); #1;
      n++;
      if (!done && (ss_n !== exp_ss || busy !== 1'b1)) bad++;
    end
    start = 1'b0;
    chk({tag, "_cycles"}, n, exp_cyc);
    chk({tag, "_data_out"}, data_out, exp_dout);
    chk({tag, "_slave_rx"}, slv_rx, exp_slv);
    chk({tag, "_ss_busy_hold"}, bad, 0);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    chk({tag, "_ss_at_done"}, ss_n, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_no_requeue"}, busy, 1'b0);
    chk({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int n;
    int bad;
    #23;
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_ss_n", ss_n, 4'hF);
    chk("rst_data_out", data_out, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_xfer("m0",  2'b00, 1'b0, 8'd0, 2'd0, 16'hA5C3, 16'h3C5A, 16'h3C5A, 16'hA5C3, 34,  4'b1110, 1'b0);
    run_xfer("m1",  2'b01, 1'b0, 8'd3, 2'd1, 16'h8001, 16'h4B2D, 16'h4B2D, 16'h8001, 136, 4'b1101, 1'b0);
    run_xfer("m2",  2'b10, 1'b0, 8'd3, 2'd0, 16'h8001, 16'h0FF0, 16'h0FF0, 16'h8001, 136, 4'b1110, 1'b0);
    run_xfer("m3",  2'b11, 1'b0, 8'd3, 2'd3, 16'h8001, 16'hC0DE, 16'hC0DE, 16'h8001, 136, 4'b0111, 1'b0);
    run_xfer("lsb", 2'b00, 1'b1, 8'd0, 2'd0, 16'h0001, 16'h8000, 16'h0001, 16'h8000, 34,  4'b1110, 1'b0);
    run_xfer("ss2", 2'b00, 1'b0, 8'd1, 2'd2, 16'h1357, 16'h2468, 16'h2468, 16'h1357, 68,  4'b1011, 1'b1);

    // Out-of-range select on a three-slave instance.
    @(negedge clk);
    mode = 2'b00; div = 8'd0; lsb_first = 1'b0; ss_sel3 = 2'd3;
    chk("ss3_idle_sclk", sclk3, 1'b0);
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    chk("ss3_busy", busy3, 1'b1);
    n = 0;
    bad = 0;
    while (!done3 && n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (ss_n3 !== 3'b111) bad++;
    end
    chk("ss3_cycles", n, 34);
    chk("ss3_no_select", bad, 0);
    chk("ss3_data_out", data_out3, 16'h0000);
    chk("ss3_mosi_end", mosi3, 1'b0);

    // Reset in the middle of XFER.
    @(negedge clk);
    mode = 2'b00; div = 8'd0; ss_sel = 2'd0; data_in = 16'h5555; slv_tx = 16'hAAAA;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_sclk", sclk, 1'b1);
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ss_n", ss_n, 4'hF);
    chk("mid_rst_sclk", sclk, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_data_out", data_out, 16'h0000);
    chk("mid_rst_mosi", mosi, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done) bad++;
    end
    chk("mid_rst_no_done", bad, 0);

    run_xfer("post", 2'b11, 1'b0, 8'd0, 2'd1, 16'hFACE, 16'h0F0F, 16'h0F0F, 16'hFACE, 34, 4'b1101, 1'b0);

`ifdef SPI_MASTER_LOOPBACK_EN
    loopback = 1'b1;
    run_xfer("lpbk", 2'b00, 1'b0, 8'd0, 2'd0, 16'h1234, 16'hFFFF, 16'h1234, 16'h1234, 34, 4'b1110, 1'b0);
    loopback = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
